// File: rtl/aes_pkg.sv
// Shared AES constants: FIPS-197 S-box tables, round constants, byte type.
// Optional: define AES_SBOX_INV_EN to include the inverse S-box table.
package aes_pkg;

  // Big-endian byte: bit 0 is the MSB.
  typedef logic [0:7] byte_t;

  localparam int unsigned NumRcon = 10;

  localparam byte_t RCON [NumRcon] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

`ifdef AES_SBOX_INV_EN
  localparam byte_t INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
    8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
    8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
    8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
    8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
    8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
    8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
    8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
    8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
    8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
    8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
    8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
    8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
    8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
    8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
    8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
    8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };
`endif

endpackage

// File: rtl/aes_sbox_if.sv
// Byte substitution bus. Optional: AES_SBOX_INV_EN adds the inv select.
interface aes_sbox_if;
  import aes_pkg::*;

  byte_t in_byte;
  byte_t out_byte;
  byte_t out_byte_q;
`ifdef AES_SBOX_INV_EN
  logic  inv;
`endif

`ifdef AES_SBOX_INV_EN
  modport master (output in_byte, output inv, input out_byte, input out_byte_q);
  modport slave  (input in_byte, input inv, output out_byte, output out_byte_q);
`else
  modport master (output in_byte, input out_byte, input out_byte_q);
  modport slave  (input in_byte, output out_byte, output out_byte_q);
`endif

endinterface

// File: rtl/aes_sbox_lut.sv
// Pure combinational S-box lookup, mapped to LUT logic via a constant table.
// Optional: AES_SBOX_INV_EN adds inv_i to select the inverse table.
module aes_sbox_lut
  import aes_pkg::*;
(
  input  byte_t in_i,
`ifdef AES_SBOX_INV_EN
  input  logic  inv_i,
`endif
  output byte_t out_o
);

  // Table lookup indexed by the unsigned byte value (bit 0 is the MSB).
  always_comb begin
`ifdef AES_SBOX_INV_EN
    out_o = inv_i ? INV_SBOX[in_i] : SBOX[in_i];
`else
    out_o = SBOX[in_i];
`endif
  end

endmodule

// File: rtl/aes_sbox.sv
// AES SubBytes unit: combinational S(in_byte) plus a registered copy.
// Optional: AES_SBOX_INV_EN adds bus.inv to select the inverse S-box.
module aes_sbox
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  aes_sbox_if.slave  bus
);

  byte_t sub_d;
  byte_t sub_q;

  aes_sbox_lut u_lut (
    .in_i  (bus.in_byte),
`ifdef AES_SBOX_INV_EN
    .inv_i (bus.inv),
`endif
    .out_o (sub_d)
  );

  // Output register; reset clears it to 00 (not S(00)).
  always_ff @(posedge clk) begin
    if (reset) begin
      sub_q <= 8'h00;
    end else begin
      sub_q <= sub_d;
    end
  end

  assign bus.out_byte   = sub_d;
  assign bus.out_byte_q = sub_q;

endmodule

// File: tb/tb_aes_sbox.sv
// Bench for aes_sbox: GF(2^8) reference model plus directed vectors.
// Optional: AES_SBOX_INV_EN exercises the inverse table.
module tb_aes_sbox;
  import aes_pkg::*;

  logic clk;
  logic reset;
  aes_sbox_if bus ();

  aes_sbox dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] fwd_m [256];
  logic [7:0] inv_m [256];
  logic [7:0] exp_q;
  bit         q_known = 1'b0;
  bit         cmp_on  = 1'b0;

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a = a_in;
    logic [7:0] b = b_in;
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S(x) = affine(x^-1) over GF(2^8) with the AES polynomial.
  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] r = 8'h00;
    if (x != 8'h00) begin
      for (int y = 1; y < 256; y++) begin
        if (gmul(x, 8'(y)) == 8'h01) r = 8'(y);
      end
    end
    return r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] model(input logic [7:0] x, input logic iv);
    return iv ? inv_m[x] : fwd_m[x];
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  logic cur_inv;
`ifdef AES_SBOX_INV_EN
  assign cur_inv = bus.inv;
`else
  assign cur_inv = 1'b0;
`endif

  // Expected register contents, tracked from what the bench drove at each edge.
  always @(posedge clk) begin
    if (reset) exp_q <= 8'h00;
    else       exp_q <= model(bus.in_byte, cur_inv);
    q_known <= 1'b1;
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      check("model_out", bus.out_byte, model(bus.in_byte, cur_inv));
      if (q_known) check("model_q", bus.out_byte_q, exp_q);
    end
  end

  logic [7:0] spot_in  [6] = '{8'h00, 8'h01, 8'h10, 8'h53, 8'hcf, 8'hff};
  logic [7:0] spot_exp [6] = '{8'h63, 8'h7c, 8'hca, 8'hed, 8'h8a, 8'h16};
  logic [7:0] sw_in    [4] = '{8'hcf, 8'h4f, 8'h3c, 8'h09};
  logic [7:0] sw_exp   [4] = '{8'h8a, 8'h84, 8'heb, 8'h01};
  bit         seen     [256];

  initial begin
    int distinct;
    int xs;
    for (int x = 0; x < 256; x++) fwd_m[x] = sbox_ref(8'(x));
    for (int x = 0; x < 256; x++) inv_m[fwd_m[x]] = 8'(x);
    // Pin the reference model to known FIPS-197 entries.
    check("model_pin_00", fwd_m[8'h00], 8'h63);
    check("model_pin_53", fwd_m[8'h53], 8'hed);
    check("model_pin_ff", fwd_m[8'hff], 8'h16);

    reset = 1'b1;
    bus.in_byte = 8'h00;
`ifdef AES_SBOX_INV_EN
    bus.inv = 1'b0;
`endif
    cmp_on = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_q", bus.out_byte_q, 8'h00);
    check("reset_out", bus.out_byte, 8'h63);
    reset = 1'b0;

    // Forward spot values, then their registered copies one edge later.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i > 0) check("spot_q", bus.out_byte_q, spot_exp[i-1]);
      bus.in_byte = spot_in[i];
      #1;
      check("spot_out", bus.out_byte, spot_exp[i]);
    end
    @(posedge clk); #1;
    check("spot_q", bus.out_byte_q, spot_exp[5]);

    // SubWord of RotWord(09CF4F3C).
    for (int i = 0; i < 4; i++) begin
      bus.in_byte = sw_in[i];
      @(negedge clk);
      check("subword", bus.out_byte, sw_exp[i]);
      @(posedge clk); #1;
    end

    // Exhaustive sweep: bijection and no X.
    distinct = 0;
    xs = 0;
    for (int x = 0; x < 256; x++) seen[x] = 1'b0;
    for (int x = 0; x < 256; x++) begin
      bus.in_byte = 8'(x);
      @(negedge clk);
      if ($isunknown(bus.out_byte)) xs++;
      else if (!seen[bus.out_byte]) begin
        seen[bus.out_byte] = 1'b1;
        distinct++;
      end
      @(posedge clk); #1;
    end
    check("sweep_distinct", 8'(distinct), 8'(256));
    check("sweep_no_x", 8'(xs), 8'h00);

    // Reset mid-stream clears only the register.
    bus.in_byte = 8'h53;
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_reset_q", bus.out_byte_q, 8'h00);
    check("mid_reset_out", bus.out_byte, 8'hed);
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_reset_q", bus.out_byte_q, 8'hed);

`ifdef AES_SBOX_INV_EN
    begin
      logic [7:0] iv_in  [4] = '{8'h63, 8'hed, 8'h16, 8'h8a};
      logic [7:0] iv_exp [4] = '{8'h00, 8'h53, 8'hff, 8'hcf};
      bus.inv = 1'b1;
      for (int i = 0; i < 4; i++) begin
        bus.in_byte = iv_in[i];
        @(negedge clk);
        check("inv_spot", bus.out_byte, iv_exp[i]);
        @(posedge clk); #1;
      end
      for (int x = 0; x < 256; x++) begin
        bus.in_byte = fwd_m[x];
        @(negedge clk);
        check("inv_roundtrip", bus.out_byte, 8'(x));
        @(posedge clk); #1;
      end
      bus.in_byte = 8'h53;
      bus.inv = 1'b0;
      #1;
      check("inv_toggle_fwd", bus.out_byte, 8'hed);
      bus.inv = 1'b1;
      #1;
      check("inv_toggle_inv", bus.out_byte, 8'h50);
      @(posedge clk); #1;
      check("inv_q", bus.out_byte_q, 8'h50);
    end
`endif

    @(negedge clk);
    cmp_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
